// File: rtl/demux1x4_deser.sv
// Registered 1-to-WIDTH demultiplexer/deserializer: serial bits are steered into
// lanes by address or internal counter, and each completed word is emitted with a valid pulse.
module demux1x4_deser #(
    parameter  int WIDTH = 4,
    localparam int SELW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             addr_mode,
    input  logic [SELW-1:0]  sel_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [SELW-1:0]  lane_cnt,
    output logic             overwrite
);

    logic [WIDTH-1:0] wrk, msk;
    logic [SELW-1:0]  cnt;
    logic             mode_q;

    logic [WIDTH-1:0] wrk_base, msk_base, wrk_nxt, msk_nxt;
    logic [SELW-1:0]  cnt_base, cnt_nxt, lane;
    logic             complete, hit;

    // A mode change aborts the partial word; a bit accepted on that edge starts a fresh word.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        wrk_base = wrk;
        msk_base = msk;
        cnt_base = cnt;
        if (addr_mode != mode_q) begin
            wrk_base = '0;
            msk_base = '0;
            cnt_base = '0;
        end

        lane     = addr_mode ? sel_in : cnt_base;
        wrk_nxt  = wrk_base;
        msk_nxt  = msk_base;
        cnt_nxt  = cnt_base;
        hit      = 1'b0;
        complete = 1'b0;

        if (din_valid) begin
            wrk_nxt[lane] = din;
            msk_nxt[lane] = 1'b1;
            hit           = addr_mode && msk_base[lane];
            complete      = &msk_nxt;
            if (!addr_mode)
                cnt_nxt = cnt_base + SELW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overwrite  <= 1'b0;
            wrk        <= '0;
            msk        <= '0;
            cnt        <= '0;
            mode_q     <= 1'b0;
        end else begin
            mode_q     <= addr_mode;
            data_valid <= complete;
            overwrite  <= hit;
            if (complete) begin
                data_out <= wrk_nxt;
                wrk      <= '0;
                msk      <= '0;
                cnt      <= '0;
            end else begin
                wrk <= wrk_nxt;
                msk <= msk_nxt;
                cnt <= cnt_nxt;
            end
        end
    end

    assign lane_cnt = cnt;

endmodule

// File: tb/tb_demux1x4_deser.sv
// Self-checking bench for demux1x4_deser (WIDTH=4): expected words go into a
// scoreboard queue as the completing bit is driven and are compared on data_valid.
module tb_demux1x4_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       addr_mode;
    logic [1:0] sel_in;
    logic [3:0] data_out;
    logic       data_valid;
    logic [1:0] lane_cnt;
    logic       overwrite;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    logic [3:0] exp_q[$];

    demux1x4_deser #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .addr_mode (addr_mode),
        .sel_in    (sel_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .lane_cnt  (lane_cnt),
        .overwrite (overwrite)
    );

    always #5 clk = ~clk;

    // Scoreboard: every valid pulse must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid data_out=%b (no word expected)", data_out);
            end else begin
                automatic logic [3:0] exp = exp_q.pop_front();
                if (data_out !== exp) begin
                    errors++;
                    $display("FAIL scoreboard_word got=%b want=%b", data_out, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, let the edge happen, return 1 time unit after it.
    task automatic step(input logic v, input logic d, input logic m, input logic [1:0] s);
        din_valid = v;
        din       = d;
        addr_mode = m;
        sel_in    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; addr_mode = 1'b0; sel_in = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (data_out !== 4'b0)   begin errors++; $display("FAIL reset_data_out got=%b want=0000", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got=%b want=0", data_valid); end
        checks++; if (lane_cnt !== 2'd0)   begin errors++; $display("FAIL reset_lane_cnt got=%0d want=0", lane_cnt); end
        checks++; if (overwrite !== 1'b0)  begin errors++; $display("FAIL reset_overwrite got=%b want=0", overwrite); end
    endtask

    task automatic test_counter_basic();
        int v0 = valid_cnt;
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        checks++; if (lane_cnt !== 2'd3)   begin errors++; $display("FAIL basic_lane_cnt3 got=%0d want=3", lane_cnt); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b want=0", data_valid); end
        exp_q.push_back(4'b1101);
        step(1, 1, 0, 0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b want=1", data_valid); end
        checks++; if (lane_cnt !== 2'd0)   begin errors++; $display("FAIL basic_cnt_wrap got=%0d want=0", lane_cnt); end
        step(0, 0, 0, 0);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b want=0", data_valid); end
        checks++; if (data_out !== 4'b1101) begin errors++; $display("FAIL basic_hold got=%b want=1101", data_out); end
        @(negedge clk);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_pulse_count got=%0d want=1", valid_cnt - v0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = 8'b1010_0011; // bit i is the i-th serial bit
        int v0 = valid_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) exp_q.push_back(4'b0011);
            if (i == 7) exp_q.push_back(4'b1010);
            step(1, bits[i], 0, 0);
            if (i == 3 || i == 4 || i == 7) begin
                checks++;
                if (data_valid !== (i != 4)) begin
                    errors++;
                    $display("FAIL b2b_valid_bit%0d got=%b want=%b", i, data_valid, (i != 4));
                end
            end
        end
        step(0, 0, 0, 0);
        checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_pulse_count got=%0d want=2", valid_cnt - v0); end
    endtask

    task automatic test_addressed();
        step(1, 1, 1, 3);
        step(1, 0, 1, 0);
        step(1, 0, 1, 2);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL addr_early_valid got=%b want=0", data_valid); end
        checks++; if (lane_cnt !== 2'd0)   begin errors++; $display("FAIL addr_lane_cnt got=%0d want=0", lane_cnt); end
        exp_q.push_back(4'b1010);
        step(1, 1, 1, 1);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL addr_valid got=%b want=1", data_valid); end
        // Second word: lane 2 written twice, the later value must win.
        step(1, 0, 1, 2);
        checks++; if (overwrite !== 1'b0)  begin errors++; $display("FAIL addr_first_write_ovw got=%b want=0", overwrite); end
        step(1, 1, 1, 2);
        checks++; if (overwrite !== 1'b1)  begin errors++; $display("FAIL addr_overwrite got=%b want=1", overwrite); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL addr_ovw_valid got=%b want=0", data_valid); end
        step(1, 1, 1, 0);
        checks++; if (overwrite !== 1'b0)  begin errors++; $display("FAIL addr_ovw_pulse got=%b want=0", overwrite); end
        step(1, 0, 1, 1);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL addr_ovw_incomplete got=%b want=0", data_valid); end
        exp_q.push_back(4'b0101);
        step(1, 0, 1, 3);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL addr_ovw_complete got=%b want=1", data_valid); end
        step(0, 0, 1, 0);
    endtask

    task automatic test_gaps();
        logic [6:0] vpat = 7'b101_1001; // bit i is din_valid in cycle i
        logic [1:0] want_cnt[7] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        for (int i = 0; i < 7; i++) begin
            if (i == 6) exp_q.push_back(4'b1111);
            step(vpat[i], 1, 0, 0);
            checks++;
            if (lane_cnt !== want_cnt[i]) begin
                errors++;
                $display("FAIL gaps_lane_cnt_cyc%0d got=%0d want=%0d", i, lane_cnt, want_cnt[i]);
            end
        end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got=%b want=1", data_valid); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_abort();
        int v0 = valid_cnt;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        checks++; if (lane_cnt !== 2'd2)   begin errors++; $display("FAIL abort_pre_cnt got=%0d want=2", lane_cnt); end
        step(0, 0, 1, 0);
        checks++; if (lane_cnt !== 2'd0)   begin errors++; $display("FAIL abort_cnt_clear got=%0d want=0", lane_cnt); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL abort_no_valid got=%b want=0", data_valid); end
        step(1, 0, 1, 0);
        step(1, 1, 1, 1);
        step(1, 1, 1, 2);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL abort_residue got=%b want=0", data_valid); end
        exp_q.push_back(4'b0110);
        step(1, 0, 1, 3);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL abort_next_word got=%b want=1", data_valid); end
        step(0, 0, 1, 0);
        @(negedge clk);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL abort_pulse_count got=%0d want=1", valid_cnt - v0); end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] bits = 4'b0010;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (lane_cnt !== 2'd0)   begin errors++; $display("FAIL rstmid_lane_cnt got=%0d want=0", lane_cnt); end
        checks++; if (data_out !== 4'b0)   begin errors++; $display("FAIL rstmid_data_out got=%b want=0000", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_data_valid got=%b want=0", data_valid); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(4'b0010);
            step(1, bits[i], 0, 0);
            checks++;
            if (data_valid !== (i == 3)) begin
                errors++;
                $display("FAIL rstmid_valid_bit%0d got=%b want=%b", i, data_valid, (i == 3));
            end
        end
        step(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_counter_basic();
        test_back_to_back();
        test_addressed();
        test_gaps();
        test_abort();
        test_reset_mid_word();
        repeat (2) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL words_outstanding got=%0d want=0", exp_q.size()); end
        checks++; if (valid_cnt != 8)    begin errors++; $display("FAIL total_valid_pulses got=%0d want=8", valid_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1x4_deser.md
# demux1x4_deser

Registered 1-to-4 demultiplexer and deserializer. It is the receive-side counterpart of the 4:1 bit-select mux used in the barrel-shifter datapath. Each accepted serial bit is steered into one lane of a WIDTH-bit word, either by an explicit lane address or by an internal lane counter. Once every lane has been written, the completed word is presented in parallel with a one-cycle valid pulse.

## Interface
Parameters:
- WIDTH, 4: number of lanes/output bits; power of two, 2..16.
- SELW, $clog2(WIDTH): lane-select width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din (and sel_in) accepted on the clock edge where this is high.
- addr_mode  input  1  1 = lane taken from sel_in; 0 = lane taken from the internal counter.
- sel_in  input  SELW  lane address; used only when addr_mode=1.
- data_out  output  WIDTH  last completed word; holds until the next completion.
- data_valid  output  1  one-cycle pulse; data_out has just been updated.
- lane_cnt  output  SELW  current internal counter value (next lane in counter mode).
- overwrite  output  1  one-cycle pulse; an addressed write hit a lane already written in the current word.

## Operation
- Internal state: working register wrk[WIDTH-1:0], written-lane mask msk[WIDTH-1:0], counter cnt[SELW-1:0], registered mode mode_q.
- Reset (async, immediate): data_out=0, data_valid=0, overwrite=0, wrk=0, msk=0, cnt=0, mode_q=0.
- Lane for an accepted bit:
  - L = sel_in when addr_mode=1.
  - L = cnt when addr_mode=0.
- Accepted bit (din_valid=1), applied on that edge:
  - wrk[L] <= din.
  - msk[L] <= 1.
  - In counter mode, cnt <= cnt+1, wrapping from WIDTH-1 to 0.
- Completion occurs when msk with bit L set equals all ones.
  - Counter mode: this is exactly when cnt=WIDTH-1.
- On completion, on the same edge:
  - data_out <= wrk with bit L replaced by din.
  - data_valid <= 1.
  - wrk <= 0, msk <= 0, cnt <= 0.
  - The next accepted bit starts a new word; back-to-back words need no idle cycle.
- Addressed overwrite: if addr_mode=1 and msk[sel_in]=1 when a bit is accepted:
  - wrk[sel_in] takes the new bit.
  - msk is unchanged.
  - overwrite <= 1 for one cycle.
  - This cannot cause completion, because that lane was already counted.
- Mode change: mode_q <= addr_mode every cycle. If addr_mode != mode_q, the partial word is aborted:
  - wrk, msk and cnt are cleared; no data_valid.
  - A bit accepted on that same edge is written into the fresh word, under the new mode.
- din_valid=0: no state change except data_valid and overwrite returning to 0.
- data_out changes only on completion or reset.

## Timing
- Latency: a completing bit sampled at edge N produces data_out and data_valid visible after edge N; data_valid deasserts after edge N+1 unless edge N+1 also completes.
- Minimum word period: WIDTH accepted bits, so continuous din_valid=1 in counter mode gives data_valid every WIDTH cycles.
- There is no backpressure; the consumer must capture data_out during the data_valid cycle or before the next completion.
- lane_cnt and overwrite are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-word clears everything immediately; the partial word is lost and no data_valid is emitted.
- Bit mapping: din accepted in lane k appears at data_out[k].

## Test plan
- Reset check: after rst, data_out=0, data_valid=0, lane_cnt=0. Then counter mode with din_valid=1 for 4 cycles, din=1,0,1,1 -> data_out=4'b1101, data_valid high exactly one cycle after the 4th edge.
- Back-to-back words: counter mode, 8 consecutive bits 1,1,0,0,0,1,0,1 -> data_valid pulses twice, with data_out=4'b0011 then 4'b1010; no gap cycle.
- Addressed mode: sel_in=3,0,2,1 with din=1,0,0,1 -> completion on the 4th bit, data_out=4'b1010. Then repeat sel_in=2 before the word is complete -> overwrite pulse, the new value lands in bit 2, completion still needs the remaining lanes.
- Gaps: counter mode with din_valid toggling 1,0,0,1,1,0,1 and din=1 -> data_out=4'b1111 one cycle after the 4th accepted bit; lane_cnt holds during idle cycles.
- Abort: two bits in counter mode, then flip addr_mode to 1 -> lane_cnt=0, no data_valid, and the next full addressed word completes normally.
- Reset mid-word: assert rst asynchronously after 3 bits -> outputs clear immediately. The next 4 bits after release form a complete word, with no residue from the aborted word.
